// File: rtl/chipselect.sv
// Address decoder: programmable base/mask region table with registered
// active-low chip selects, lowest index wins on overlap.
module chipselect #(
  parameter int NUM_SELECTS  = 8,
  parameter int ADDR_W       = 32,
  parameter int REGION_SHIFT = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_sel,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [ADDR_W-1:0]      cfg_mask,
  input  logic                   cfg_en,
  output logic [NUM_SELECTS-1:0] cs_n,
  output logic [3:0]             cs_idx,
  output logic                   hit,
  output logic                   miss
);

  logic [ADDR_W-1:0]      base [NUM_SELECTS];
  logic [ADDR_W-1:0]      mask [NUM_SELECTS];
  logic [NUM_SELECTS-1:0] en;

  logic [NUM_SELECTS-1:0] match;
  logic [NUM_SELECTS-1:0] csn_d;
  logic [3:0]             idx_d;
  logic                   any_d;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SELECTS; i++) begin
      match[i] = en[i] &&
        ((addr & mask[i]) == (base[i] & mask[i]));
    end
  end

  // Scan high to low so the lowest matching index is the last one kept.
  always_comb begin
    idx_d = '0;
    any_d = 1'b0;
    csn_d = '1;
    for (int i = NUM_SELECTS - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx_d = 4'(i);
        any_d = 1'b1;
      end
    end
    for (int j = 0; j < NUM_SELECTS; j++) begin
      csn_d[j] = ~(any_d && (idx_d == 4'(j)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SELECTS; i++) begin
        base[i] <= ADDR_W'(i) << REGION_SHIFT;
        mask[i] <= {ADDR_W{1'b1}} << REGION_SHIFT;
        en[i]   <= 1'b1;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_SELECTS; i++) begin
        if (cfg_sel == 4'(i)) begin
          base[i] <= cfg_base;
          mask[i] <= cfg_mask;
          en[i]   <= cfg_en;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n   <= '1;
      cs_idx <= '0;
      hit    <= 1'b0;
      miss   <= 1'b0;
    end else begin
      cs_n   <= csn_d;
      cs_idx <= idx_d;
      hit    <= any_d;
      miss   <= ~any_d;
    end
  end

endmodule

// File: tb/tb_chipselect.sv
// Directed bench for chipselect: default map sweep, reprogramming,
// priority, disable/bad index and asynchronous reset.
module tb_chipselect;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        cfg_we;
  logic [3:0]  cfg_sel;
  logic [31:0] cfg_base;
  logic [31:0] cfg_mask;
  logic        cfg_en;
  logic [7:0]  cs_n;
  logic [3:0]  cs_idx;
  logic        hit;
  logic        miss;

  int total = 0;
  int bad   = 0;

  chipselect #(
    .NUM_SELECTS(8),
    .ADDR_W(32),
    .REGION_SHIFT(28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .cfg_we(cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_base(cfg_base),
    .cfg_mask(cfg_mask),
    .cfg_en(cfg_en),
    .cs_n(cs_n),
    .cs_idx(cs_idx),
    .hit(hit),
    .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag,
                            input logic [7:0] e_csn,
                            input logic [3:0] e_idx,
                            input logic e_hit,
                            input logic e_miss);
    chk({tag, ".cs_n"}, 32'(cs_n), 32'(e_csn));
    chk({tag, ".idx"},  32'(cs_idx), 32'(e_idx));
    chk({tag, ".hit"},  32'(hit), 32'(e_hit));
    chk({tag, ".miss"}, 32'(miss), 32'(e_miss));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] sel,
                     input logic [31:0] b,
                     input logic [31:0] m,
                     input logic e);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_base = b;
    cfg_mask = m;
    cfg_en   = e;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    logic [7:0]  ecsn;

    rst      = 1'b1;
    addr     = 32'h1000_0000;
    cfg_we   = 1'b0;
    cfg_sel  = 4'd0;
    cfg_base = 32'h0;
    cfg_mask = 32'h0;
    cfg_en   = 1'b0;
    #3;
    expect_out("reset", 8'hFF, 4'd0, 1'b0, 1'b0);
    step();
    expect_out("reset_hold", 8'hFF, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("release", 8'hFD, 4'd1, 1'b1, 1'b0);

    for (int k = 0; k <= 16; k++) begin
      a    = 32'(k) << 28;
      addr = a;
      step();
      r = k % 16;
      if (r < 8) begin
        ecsn = ~(8'h01 << r);
        expect_out($sformatf("sweep%0d", k), ecsn, 4'(r), 1'b1, 1'b0);
      end else begin
        expect_out($sformatf("sweep%0d", k), 8'hFF, 4'd0, 1'b0, 1'b1);
      end
    end

    addr = 32'h3000_0000;
    cfg(4'd3, 32'h8000_0000, 32'hFFF0_0000, 1'b1);
    expect_out("wr_same_cycle", 8'hF7, 4'd3, 1'b1, 1'b0);
    step();
    expect_out("wr_old_region", 8'hFF, 4'd0, 1'b0, 1'b1);
    addr = 32'h8001_2345;
    step();
    expect_out("reprog_hit", 8'hF7, 4'd3, 1'b1, 1'b0);
    addr = 32'h8010_0000;
    step();
    expect_out("reprog_miss", 8'hFF, 4'd0, 1'b0, 1'b1);

    addr = 32'h1000_0000;
    cfg(4'd2, 32'h0, 32'h0, 1'b1);
    step();
    expect_out("prio_low", 8'hFD, 4'd1, 1'b1, 1'b0);
    addr = 32'h9000_0000;
    step();
    expect_out("prio_all", 8'hFB, 4'd2, 1'b1, 1'b0);
    addr = 32'h8001_2345;
    step();
    expect_out("prio_2_over_3", 8'hFB, 4'd2, 1'b1, 1'b0);

    cfg(4'd2, 32'h2000_0000, 32'hF000_0000, 1'b1);
    cfg(4'd5, 32'h5000_0000, 32'hF000_0000, 1'b0);
    addr = 32'h5000_0000;
    step();
    expect_out("disabled", 8'hFF, 4'd0, 1'b0, 1'b1);
    cfg(4'd12, 32'h0, 32'h0, 1'b1);
    addr = 32'h9000_0000;
    step();
    expect_out("bad_idx", 8'hFF, 4'd0, 1'b0, 1'b1);
    addr = 32'h4000_0000;
    step();
    expect_out("bad_idx_e4", 8'hEF, 4'd4, 1'b1, 1'b0);

    addr = 32'h2000_0000;
    step();
    expect_out("pre_areset", 8'hFB, 4'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("areset", 8'hFF, 4'd0, 1'b0, 1'b0);
    step();
    rst  = 1'b0;
    addr = 32'h3000_0000;
    step();
    expect_out("restored3", 8'hF7, 4'd3, 1'b1, 1'b0);
    addr = 32'h5000_0000;
    step();
    expect_out("restored5", 8'hDF, 4'd5, 1'b1, 1'b0);
    addr = 32'h8001_2345;
    step();
    expect_out("restored_miss", 8'hFF, 4'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
